uart_rx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/byte_fifo.sv | 69 ++++++
 rtl/uart_rx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : shared types and constants for the UART receive path
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_t;

    localparam int UART_CLKS_PER_BIT_25M = 217;
    localparam int UART_DATA_BITS        = 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
//------------------------------------------------------------------------------
// byte_fifo : synchronous first-word-fall-through byte FIFO, 2^DEPTH_LOG2 deep
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  valid,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   C_FULL     = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   C_LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_do_pop;
    logic                  w_do_push;

    assign valid     = (r_level != '0);
    assign full      = (r_level == C_FULL);
    assign level     = r_level;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & valid;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + C_LVL_ONE;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - C_LVL_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// uart_rx_fifo : 8N1 UART receiver with FWFT byte FIFO, framing/overflow flags
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling (+1 cycle latency)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT    = UART_CLKS_PER_BIT_25M,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       uart_rx_pin,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic                       framing_error,
    output logic                       overflow,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

    localparam logic [15:0] C_BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  C_LAST_BIT = 3'(UART_DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] C_START_AT = 16'((CLKS_PER_BIT - 1) / 2 + 1);
`else
    localparam logic [15:0] C_START_AT = 16'((CLKS_PER_BIT - 1) / 2);
`endif

    logic        r_sync1;
    logic        r_rxs;
    rx_state_t   r_state;
    rx_state_t   w_state_nx;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nx;
    logic [2:0]  r_bitn;
    logic [2:0]  w_bitn_nx;
    logic [7:0]  r_shreg;
    logic [7:0]  w_shreg_nx;
    logic        r_framing_error;
    logic        r_overflow;
    logic        w_samp;
    logic        w_push;
    logic        w_frame_err;
    logic        w_fifo_full;
    logic        w_overflow;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0]  r_hist;

    // Decisions fire one cycle late, so the whole bit grid is shifted by one and
    // r_hist[1], r_hist[0], r_rxs are the nominal -1, 0, +1 samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_rxs};
        end
    end

    assign w_samp = maj3(r_hist[1], r_hist[0], r_rxs);
`else
    assign w_samp = r_rxs;
`endif

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt + 16'd1;
        w_bitn_nx   = r_bitn;
        w_shreg_nx  = r_shreg;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        unique case (r_state)
            WAIT_IDLE: begin
                w_cnt_nx = '0;
                if (r_rxs) w_state_nx = IDLE;
            end
            IDLE: begin
                w_cnt_nx = '0;
                if (!r_rxs) w_state_nx = START;
            end
            START: begin
                if (r_cnt == C_START_AT) begin
                    w_cnt_nx   = '0;
                    w_bitn_nx  = '0;
                    w_state_nx = w_samp ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_nx   = '0;
                    w_shreg_nx = {w_samp, r_shreg[7:1]};
                    w_bitn_nx  = r_bitn + 3'd1;
                    if (r_bitn == C_LAST_BIT) w_state_nx = STOP;
                end
            end
            STOP: begin
                if (r_cnt == C_BIT_LAST) begin
                    w_cnt_nx    = '0;
                    w_push      = w_samp;
                    w_frame_err = ~w_samp;
                    w_state_nx  = w_samp ? IDLE : WAIT_IDLE;
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = WAIT_IDLE;
            end
        endcase
    end

    assign w_overflow = w_push & w_fifo_full & ~(rd_valid & rd_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1         <= 1'b1;
            r_rxs           <= 1'b1;
            r_state         <= WAIT_IDLE;
            r_cnt           <= '0;
            r_bitn          <= '0;
            r_shreg         <= '0;
            r_framing_error <= 1'b0;
            r_overflow      <= 1'b0;
        end else begin
            r_sync1         <= uart_rx_pin;
            r_rxs           <= r_sync1;
            r_state         <= w_state_nx;
            r_cnt           <= w_cnt_nx;
            r_bitn          <= w_bitn_nx;
            r_shreg         <= w_shreg_nx;
            r_framing_error <= w_frame_err;
            r_overflow      <= w_overflow;
        end
    end

    assign framing_error = r_framing_error;
    assign overflow      = r_overflow;

    byte_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_shreg_nx),
        .pop       (rd_ready),
        .head      (rd_data),
        .valid     (rd_valid),
        .full      (w_fifo_full),
        .level     (fifo_level)
    );

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
//------------------------------------------------------------------------------
// tb_uart_rx_fifo : scoreboard bench for uart_rx_fifo (16 clocks/bit, 4-deep FIFO)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    localparam int C_CPB   = 16;
    localparam int C_DL    = 2;
    localparam int C_DEPTH = 4;
    // Edges from line-low to the stop sample: 2 sync + 1 idle + mid start + 9 bits.
    localparam int C_STOP_EDGE = (C_CPB - 1) / 2 + 9 * C_CPB + 3;

    logic         clock = 1'b0;
    logic         reset;
    logic         uart_rx_pin;
    logic         rd_ready;
    logic [7:0]   rd_data;
    logic         rd_valid;
    logic         framing_error;
    logic         overflow;
    logic [C_DL:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    int valid_cycles = 0;
    int exp_ferr = 0;
    int exp_ovf = 0;
    int model_level = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    uart_rx_fifo #(
        .CLKS_PER_BIT    (C_CPB),
        .FIFO_DEPTH_LOG2 (C_DL)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .uart_rx_pin   (uart_rx_pin),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .framing_error (framing_error),
        .overflow      (overflow),
        .fifo_level    (fifo_level)
    );

    // Monitor: counts flag pulses and checks every popped byte against the scoreboard.
    always @(negedge clock) begin
        logic [7:0] e;
        if (framing_error === 1'b1) ferr_cnt++;
        if (overflow === 1'b1) ovf_cnt++;
        if (framing_error === 1'b1 || overflow === 1'b1) begin
            checks++;
            if (framing_error === 1'b1 && overflow === 1'b1) begin
                errors++;
                $display("FAIL flag_coincide: got both flags high, required at most one");
            end
        end
        if (reset === 1'b0) begin
            if (rd_valid === 1'b1) valid_cycles++;
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_data: got %02h, required no byte", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        errors++;
                        $display("FAIL pop_data: got %02h, required %02h", rd_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx_pin = 1'b0;
        tick(C_CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_pin = b[i];
            tick(C_CPB);
        end
        uart_rx_pin = stop_bit;
        tick(C_CPB);
    endtask

    // Reference model of one good frame arriving: drained at once, queued, or dropped.
    task automatic model_accept(input logic [7:0] b);
        if (rd_ready) begin
            exp_q.push_back(b);
        end else if (model_level < C_DEPTH) begin
            model_level++;
            exp_q.push_back(b);
        end else begin
            exp_ovf++;
        end
    endtask

    task automatic good_frame(input logic [7:0] b);
        model_accept(b);
        send_frame(b, 1'b1);
        tick(3);
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        tick(C_DEPTH + 4);
        model_level = 0;
        chk("drain_level", 32'(fifo_level), 0);
    endtask

    initial begin
        int v0, f0, o0, n, mode, gl;
        logic [7:0] b;
        logic [7:0] part;

        reset = 1'b1;
        uart_rx_pin = 1'b1;
        rd_ready = 1'b0;
        tick(3);
        chk("reset_valid", 32'(rd_valid), 0);
        chk("reset_level", 32'(fifo_level), 0);
        chk("reset_ferr", 32'(framing_error), 0);
        chk("reset_ovf", 32'(overflow), 0);
        reset = 1'b0;
        tick(5);

        // Single frame, consumer always ready.
        rd_ready = 1'b1;
        v0 = valid_cycles;
        good_frame(8'hA5);
        tick(3);
        chk("single_valid_cycles", 32'(valid_cycles - v0), 1);
        chk("single_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        chk("single_ovf", 32'(ovf_cnt), 32'(exp_ovf));

        // Start-bit glitch then a clean frame.
        v0 = valid_cycles;
        uart_rx_pin = 1'b0;
        tick(4);
        uart_rx_pin = 1'b1;
        tick(30);
        chk("glitch_valid_cycles", 32'(valid_cycles - v0), 0);
        chk("glitch_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        good_frame(8'h3C);
        tick(3);
        chk("glitch_then_frame", 32'(exp_q.size()), 0);

        // Framing error, line held low, then recovery.
        exp_ferr++;
        send_frame(8'h0F, 1'b0);
        tick(5);
        chk("ferr_pulse", 32'(ferr_cnt), 32'(exp_ferr));
        chk("ferr_level", 32'(fifo_level), 0);
        tick(95);
        uart_rx_pin = 1'b1;
        tick(10);
        v0 = valid_cycles;
        good_frame(8'h81);
        tick(3);
        chk("ferr_recover", 32'(exp_q.size()), 0);
        chk("ferr_recover_cycles", 32'(valid_cycles - v0), 1);

        // Overflow: five frames into a four-deep FIFO with no consumer.
        rd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) good_frame(8'(i));
        chk("ovf_level", 32'(fifo_level), 32'(model_level));
        chk("ovf_valid", 32'(rd_valid), 1);
        chk("ovf_pulse", 32'(ovf_cnt), 32'(exp_ovf));
        drain();
        chk("ovf_drained", 32'(exp_q.size()), 0);

        // Full FIFO with a pop landing on the fifth stop sample.
        rd_ready = 1'b0;
        for (int i = 1; i <= 4; i++) good_frame(8'(i));
        exp_q.push_back(8'h05);
        fork
            send_frame(8'h05, 1'b1);
            begin
                tick(C_STOP_EDGE);
                rd_ready = 1'b1;
                tick(1);
                rd_ready = 1'b0;
            end
        join
        tick(3);
        chk("fullpop_ovf", 32'(ovf_cnt), 32'(exp_ovf));
        chk("fullpop_level", 32'(fifo_level), C_DEPTH);
        chk("fullpop_remaining", 32'(exp_q.size()), 4);
        drain();
        chk("fullpop_drained", 32'(exp_q.size()), 0);

        // Reset in the middle of data bit 3 with a byte already buffered.
        rd_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        tick(3);
        chk("prereset_level", 32'(fifo_level), 1);
        part = 8'h99;
        uart_rx_pin = 1'b0;
        tick(C_CPB);
        for (int i = 0; i < 3; i++) begin
            uart_rx_pin = part[i];
            tick(C_CPB);
        end
        uart_rx_pin = part[3];
        tick(C_CPB / 2);
        f0 = ferr_cnt;
        o0 = ovf_cnt;
        reset = 1'b1;
        uart_rx_pin = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("midreset_valid", 32'(rd_valid), 0);
        chk("midreset_level", 32'(fifo_level), 0);
        chk("midreset_ferr", 32'(framing_error), 0);
        chk("midreset_ovf", 32'(overflow), 0);
        tick(1);
        chk("midreset_flag_count", 32'(ferr_cnt - f0 + ovf_cnt - o0), 0);
        model_level = 0;
        tick(10);
        rd_ready = 1'b1;
        good_frame(8'h55);
        tick(3);
        chk("postreset_frame", 32'(exp_q.size()), 0);

        // Randomised mix of streaming, glitches, framing errors and bursts.
        for (int it = 0; it < 12; it++) begin
            mode = $urandom_range(0, 2);
            b = 8'($urandom);
            if (mode == 0) begin
                rd_ready = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    gl = $urandom_range(1, 5);
                    uart_rx_pin = 1'b0;
                    tick(gl);
                    uart_rx_pin = 1'b1;
                    tick(12);
                end
                good_frame(b);
                tick($urandom_range(2, 10));
            end else if (mode == 1) begin
                rd_ready = 1'b1;
                exp_ferr++;
                send_frame(b, 1'b0);
                tick($urandom_range(20, 60));
                uart_rx_pin = 1'b1;
                tick(5);
                chk("rand_ferr", 32'(ferr_cnt), 32'(exp_ferr));
            end else begin
                rd_ready = 1'b0;
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) good_frame(8'($urandom));
                chk("rand_burst_level", 32'(fifo_level), 32'(model_level));
                chk("rand_burst_ovf", 32'(ovf_cnt), 32'(exp_ovf));
                drain();
            end
        end

        tick(20);
        chk("final_scoreboard_empty", 32'(exp_q.size()), 0);
        chk("final_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        chk("final_ovf", 32'(ovf_cnt), 32'(exp_ovf));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
